// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Define MULDIV_EARLY_OUT_EN to let multiplies stop once the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } stateType;

    stateType        state;
    logic [2:0]      opReg;
    logic [CW-1:0]   counter;
    logic [2*W-1:0]  prod;
    logic [2*W-1:0]  mcand;
    logic [W-1:0]    mplier;
    logic            negMain;
    logic            negRem;
    logic            divZero;
    logic            divOvf;
    logic [W-1:0]    staged;

    logic            aSigned;
    logic            bSigned;
    logic            aNeg;
    logic            bNeg;
    logic [W-1:0]    magA;
    logic [W-1:0]    magB;
    logic [W-1:0]    minVal;
    logic            zeroDivisor;
    logic            overflow;

    // Operand decode for the request presented in IDLE.
    always_comb begin
        minVal      = {1'b1, {(W-1){1'b0}}};
        aSigned     = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        bSigned     = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        aNeg        = aSigned && SrcA[W-1];
        bNeg        = bSigned && SrcB[W-1];
        magA        = aNeg ? -SrcA : SrcA;
        magB        = bNeg ? -SrcB : SrcB;
        zeroDivisor = op[2] && (SrcB == '0);
        overflow    = ((op == 3'b100) || (op == 3'b110)) && (SrcA == minVal) && (SrcB == '1);
    end

    logic [W:0]      remShift;
    logic [W:0]      diff;
    logic [2*W-1:0]  mulNext;
    logic [W-1:0]    mplierShift;
    logic            lastIter;

    // Divide keeps {remainder, quotient} in prod; the top W+1 bits after a left shift form the trial remainder.
    always_comb begin
        remShift    = prod[2*W-1:W-1];
        diff        = remShift - {1'b0, mplier};
        mulNext     = prod + (mplier[0] ? mcand : '0);
        mplierShift = mplier >> 1;
`ifdef MULDIV_EARLY_OUT_EN
        lastIter    = (counter == CW'(1)) || (!opReg[2] && (mplierShift == '0));
`else
        lastIter    = (counter == CW'(1));
`endif
    end

    logic [2*W-1:0]  mulRes;
    logic [W-1:0]    mulOut;
    logic [W-1:0]    quo;
    logic [W-1:0]    rem;
    logic [W-1:0]    divQ;
    logic [W-1:0]    divR;
    logic [W-1:0]    fixValue;

    // Sign correction and result selection; a zero divisor leaves the raw dividend in prod's low half.
    always_comb begin
        mulRes   = negMain ? -prod : prod;
        mulOut   = (opReg[1:0] == 2'b00) ? mulRes[W-1:0] : mulRes[2*W-1:W];
        quo      = prod[W-1:0];
        rem      = prod[2*W-1:W];
        divQ     = divZero ? '1 : (divOvf ? minVal : (negMain ? -quo : quo));
        divR     = divZero ? prod[W-1:0] : (divOvf ? '0 : (negRem ? -rem : rem));
        fixValue = opReg[2] ? (opReg[1] ? divR : divQ) : mulOut;
    end

    // Control FSM with datapath; busy, done and Result are all registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            opReg   <= '0;
            counter <= '0;
            prod    <= '0;
            mcand   <= '0;
            mplier  <= '0;
            negMain <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            divOvf  <= 1'b0;
            staged  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Result  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opReg   <= op;
                        busy    <= 1'b1;
                        counter <= CW'(W);
                        negMain <= aNeg ^ bNeg;
                        negRem  <= aNeg;
                        divZero <= zeroDivisor;
                        divOvf  <= overflow;
                        mplier  <= magB;
                        if (op[2]) begin
                            prod  <= {{W{1'b0}}, (zeroDivisor ? SrcA : magA)};
                            mcand <= '0;
                            state <= (zeroDivisor || overflow) ? FIX : CALC;
                        end else begin
                            prod  <= '0;
                            mcand <= {{W{1'b0}}, magA};
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    counter <= counter - CW'(1);
                    if (opReg[2]) begin
                        if (!diff[W]) begin
                            prod <= {diff[W-1:0], prod[W-2:0], 1'b1};
                        end else begin
                            prod <= {remShift[W-1:0], prod[W-2:0], 1'b0};
                        end
                    end else begin
                        prod   <= mulNext;
                        mcand  <= mcand << 1;
                        mplier <= mplierShift;
                    end
                    if (lastIter) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    staged <= fixValue;
                    state  <= DONE;
                end
                DONE: begin
                    Result <= staged;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
